// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative RV64M integer divider (DIV, DIVU, REM, REMU).
// Computes one quotient bit per cycle with a restoring algorithm. Divide by
// zero and signed overflow skip the iteration and go straight to writeback.
// The result goes directly to the register-bank write port.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request, sampled only in IDLE
//   op               00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend/divisor rs1/rs2 values, captured on accept
//   rd               destination register, captured on accept
//   flush            abort; returns to IDLE on the next edge
//   busy             high while not IDLE (core stall)
//   wen/wa/wd        register-bank write port; wen pulses for one cycle
//
// Optional feature (macro DIV_EARLY_OUT_EN): when |dividend| < |divisor| and
// divisor != 0, skip the iteration. The quotient is 0 and the remainder is
// the dividend.
module muldiv_divider #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [AW-1:0]    rd,
  input  logic             flush,
  output logic             busy,
  output logic             wen,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd
);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [AW-1:0]    rd_q;
  logic             is_rem;
  logic             neg_res;
  logic             wen_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;
  logic             ovf;
  logic             early_out;
  logic             special;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] res_mag;
  logic [WIDTH-1:0] res_final;

  // Accept-time decode. The magnitudes work for the most negative value as
  // well: its negation keeps the same bit pattern, which is the correct
  // unsigned magnitude.
  always_comb begin
    a_neg       = ~op[0] & dividend[WIDTH-1];
    b_neg       = ~op[0] & divisor[WIDTH-1];
    mag_a       = a_neg ? -dividend : dividend;
    mag_b       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    ovf         = ~op[0] & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early_out   = (mag_a < mag_b) & ~div_zero;
`else
    early_out   = 1'b0;
`endif
    special     = div_zero | ovf | early_out;
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? dividend : '1;
    else if (ovf)
      special_res = op[1] ? '0 : dividend;
    else if (early_out)
      special_res = op[1] ? dividend : '0;
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so WIDTH+1 bits hold the shifted value and the sign of the trial
  // subtraction.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    fits      = ~diff[WIDTH];
    rem_nxt   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt   = {quo[WIDTH-2:0], fits};
    res_mag   = is_rem ? rem_nxt : quo_nxt;
    res_final = neg_res ? -res_mag : res_mag;
  end

  // Control FSM and datapath registers. flush overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      rd_q    <= '0;
      is_rem  <= 1'b0;
      neg_res <= 1'b0;
      wen_q   <= 1'b0;
      wa      <= '0;
      wd      <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      wen_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wen_q <= 1'b0;
          if (start) begin
            rd_q    <= rd;
            is_rem  <= op[1];
            neg_res <= op[1] ? a_neg : (a_neg ^ b_neg);
            if (special) begin
              state <= WB;
              wen_q <= (rd != '0);
              wa    <= rd;
              wd    <= special_res;
            end else begin
              state <= CALC;
              cnt   <= CW'(WIDTH);
              quo   <= mag_a;
              rem   <= '0;
              dvs   <= mag_b;
            end
          end
        end
        CALC: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= WB;
            wen_q <= (rd_q != '0);
            wa    <= rd_q;
            wd    <= res_final;
          end
        end
        WB: begin
          state <= IDLE;
          wen_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  // A flush during WB must block the write in that same cycle.
  assign wen  = wen_q & ~flush;

endmodule

// File: tb/tb_muldiv_divider.sv
// tb_muldiv_divider: self-checking bench for muldiv_divider.
// Expected writes go into a scoreboard queue when a request is driven. The
// monitor pops them when wen is seen and checks wa, wd and the edge number.
module tb_muldiv_divider;

  localparam int L = 65;
  localparam int S = 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int E = 1;
`else
  localparam int E = 65;
`endif

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [4:0]  rd;
  logic        flush;
  logic        busy;
  logic        wen;
  logic [4:0]  wa;
  logic [63:0] wd;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
    int          due;
  } sb_t;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] expWd;
    int          lat;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[17];
  int   checks;
  int   errors;
  int   edgeCount;
  int   wenCount;

  muldiv_divider #(.WIDTH(64), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .rd(rd), .flush(flush),
    .busy(busy), .wen(wen), .wa(wa), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Label each edge. At a negedge, the upcoming edge is edgeCount+1.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Write-port monitor: every wen must match the oldest scoreboard entry.
  always @(negedge clk) begin
    sb_t e;
    #1;
    if (rst_n && wen) begin
      wenCount++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wen actual wa=%0d wd=0x%0h expected no write", wa, wd);
      end else begin
        e = sb.pop_front();
        checkOutput("wa", 64'(wa), 64'(e.wa));
        checkOutput("wd", wd, e.wd);
        checkOutput("wen_edge", 64'(edgeCount + 1), 64'(e.due));
      end
    end
  end

  // Drive one request for one cycle, starting at a negedge. Returns the
  // accepting edge label.
  task automatic launch(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] r, input logic [63:0] expWd, input int lat,
                        input bit expectWrite, output int acc);
    op       = o;
    dividend = a;
    divisor  = b;
    rd       = r;
    start    = 1'b1;
    acc      = edgeCount + 1;
    if (expectWrite) sb.push_back('{r, expWd, acc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic toEdge(input int n);
    int guard = 0;
    while (edgeCount + 1 < n && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] r, input logic [63:0] expWd, input int lat,
                               input bit expectWrite);
    int acc;
    int cycles;
    launch(o, a, b, r, expWd, lat, expectWrite, acc);
    waitIdle(cycles);
    checkOutput("busy_cycles", 64'(cycles), 64'(lat));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int cycles;
    int wenBefore;

    vecs[0]  = '{DIV,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  64'hFFFF_FFFF_FFFF_FFFA, L};
    vecs[1]  = '{REM,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, L};
    vecs[2]  = '{REMU, 64'd20, 64'd3, 5'd7, 64'd2, L};
    vecs[3]  = '{DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 64'h7FFF_FFFF_FFFF_FFFF, L};
    vecs[4]  = '{DIV,  64'd7, 64'd0, 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, S};
    vecs[5]  = '{REM,  64'd7, 64'd0, 5'd10, 64'd7, S};
    vecs[6]  = '{DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'h8000_0000_0000_0000, S};
    vecs[7]  = '{REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'd0, S};
    vecs[8]  = '{DIVU, 64'd3, 64'd9, 5'd13, 64'd0, E};
    vecs[9]  = '{REM,  64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, E};
    vecs[10] = '{DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd15, 64'hFFFF_FFFF_FFFF_FFF2, L};
    vecs[11] = '{REMU, 64'd7, 64'd0, 5'd16, 64'd7, S};
    vecs[12] = '{DIVU, 64'd5, 64'd0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, S};
    vecs[13] = '{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 64'd3, L};
    vecs[14] = '{REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, L};
    vecs[15] = '{DIV,  64'h8000_0000_0000_0000, 64'd1, 5'd20, 64'h8000_0000_0000_0000, L};
    vecs[16] = '{DIVU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21, 64'd0, E};

    checks    = 0;
    errors    = 0;
    edgeCount = 0;
    wenCount  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    op        = 2'b00;
    dividend  = '0;
    divisor   = '0;
    rd        = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_wen", 64'(wen), 64'd0);
    checkOutput("reset_wa", 64'(wa), 64'd0);
    checkOutput("reset_wd", wd, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expWd, vecs[i].lat, 1'b1);

    // wa/wd keep the last write after returning to idle.
    repeat (3) @(negedge clk);
    checkOutput("hold_wa", 64'(wa), 64'd21);
    checkOutput("hold_wd", wd, 64'd0);

    // Flush at edge 30 of DIV 100/7: no write; a restart at edge 32 works.
    launch(DIV, 64'd100, 64'd7, 5'd4, 64'd14, L, 1'b0, acc);
    toEdge(acc + 30);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy_e31", 64'(busy), 64'd0);
    toEdge(acc + 32);
    applyStimulus(DIV, 64'd100, 64'd7, 5'd4, 64'd14, L, 1'b1);

    // Same sequence with reset asserted across edge 30.
    launch(DIV, 64'd100, 64'd7, 5'd4, 64'd14, L, 1'b0, acc);
    toEdge(acc + 30);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy_e31", 64'(busy), 64'd0);
    checkOutput("rst_wa", 64'(wa), 64'd0);
    checkOutput("rst_wd", wd, 64'd0);
    rst_n = 1'b1;
    toEdge(acc + 32);
    applyStimulus(DIV, 64'd100, 64'd7, 5'd4, 64'd14, L, 1'b1);

    // rd=0: full busy timing with no write.
    applyStimulus(DIVU, 64'd9, 64'd3, 5'd0, 64'd3, L, 1'b0);

    // start during an in-flight op is ignored; exactly one write.
    wenBefore = wenCount;
    launch(DIV, 64'd100, 64'd7, 5'd24, 64'd14, L, 1'b1, acc);
    toEdge(acc + 10);
    op       = DIVU;
    dividend = 64'd50;
    divisor  = 64'd5;
    rd       = 5'd25;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(cycles);
    checkOutput("ignore_idle_edge", 64'(edgeCount + 1), 64'(acc + L + 1));
    checkOutput("ignore_wen_count", 64'(wenCount - wenBefore), 64'd1);

    // A flush in the WB cycle of a special case blocks the write there.
    launch(DIV, 64'd7, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, S, 1'b0, acc);
    flush = 1'b1;
    #1;
    checkOutput("wbflush_busy", 64'(busy), 64'd1);
    checkOutput("wbflush_wen", 64'(wen), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("wbflush_idle", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_divider.md
Name: muldiv_divider

Overview:
- Iterative RV64M integer divider; executes DIV, DIVU, REM and REMU.
- Sits directly upstream of the register bank and drives its write port (wen, wa, wd) for the cycle the result is ready.
- Execute control stalls the unicycle core while busy is high.
- One quotient bit per cycle, restoring algorithm; special cases resolve early.

Parameters:
WIDTH, 64, operand/result width in bits.
DEPTH, 32, register count; destination address width is $clog2(DEPTH).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
dividend  input  WIDTH  rs1 value; captured on accept.
divisor  input  WIDTH  rs2 value; captured on accept.
rd  input  $clog2(DEPTH)  destination register; captured on accept.
flush  input  1  abort in-flight operation.
busy  output  1  high while state != IDLE.
wen  output  1  register-bank write enable; one-cycle pulse.
wa  output  $clog2(DEPTH)  register-bank write address.
wd  output  WIDTH  register-bank write data.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, busy 0, wen 0, wa 0, wd 0, iteration counter 0. Reset mid-operation discards the operation; no write is issued.
- States:
  - IDLE: busy=0. start=1 accepts and latches op, operands and rd. Next state is WB if a special case applies, otherwise CALC with counter=WIDTH.
  - CALC: one restoring step per cycle on |dividend|, |divisor| (unsigned ops use raw values); counter decrements. When counter reaches 1, next state is WB.
  - WB: wen=1 for exactly this cycle; wa=rd; wd=result. Next state IDLE.
- Latency, counting rising edges from the accepting edge:
  - normal case: wen high WIDTH+1 edges later (65 for WIDTH=64).
  - special case: wen high 1 edge later.
- start during busy (CALC or WB) is ignored. No queuing.
- wa/wd are registered and hold their last values after WB until the next WB; only wen qualifies them.
- rd==0: the full sequence runs and busy timing is unchanged, but wen stays 0 in WB.
- Sign rules for DIV/REM:
  - quotient is negated when operand signs differ;
  - remainder takes the sign of the dividend;
  - two's complement, truncated to WIDTH.
- Special cases (RISC-V spec):
  - divisor==0: quotient all-ones; remainder = dividend (all four ops).
  - signed overflow, dividend=100..0 and divisor=all-ones, DIV/REM only: quotient = dividend, remainder = 0.
- flush=1 in any state returns to IDLE on the next edge, with wen=0 that cycle. flush with start in IDLE: flush wins and nothing is accepted. flush has priority over WB, so a WB-cycle flush suppresses wen combinationally.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: a third special case is decoded in IDLE. If |dividend| < |divisor| (unsigned compare on the sign-adjusted magnitudes; raw values for DIVU/REMU) and divisor != 0, the block goes straight to WB with quotient 0 and remainder = dividend (original sign). Latency is 1 edge.
- Undefined: such operands take the full CALC path; the result is identical and latency is WIDTH+1.
- The bench checks latency under both builds.

Test Plan:
- DIV 20 / -3, rd=5: wen pulses once at edge 65, wa=5, wd=-6 (0xFFFF_FFFF_FFFF_FFFA); busy high edges 1..65.
- REM -20 / 3 -> wd=-2; REMU 20 / 3 -> wd=2; DIVU 0xFFFF_FFFF_FFFF_FFFF / 2 -> wd=0x7FFF_FFFF_FFFF_FFFF.
- DIV 7 / 0 -> wd=all-ones at edge 1. REM 7 / 0 -> wd=7. DIV 0x8000_0000_0000_0000 / -1 -> wd=0x8000_0000_0000_0000; REM of the same operands -> wd=0. All special cases give wen at edge 1.
- Start DIV 100/7, assert flush at edge 30: busy=0 at edge 31, wen never asserts. A new start at edge 32 is accepted normally. The same sequence with rst_n low at edge 30 behaves identically.
- rd=0, DIVU 9/3: busy timing is normal and wen stays 0. start pulsed at edge 10 of an in-flight op is ignored, and exactly one wen is seen.
- DIV_EARLY_OUT_EN defined: DIVU 3/9 -> wd=0 at edge 1; REM -3/9 -> wd=-3 at edge 1. Undefined build: same wd at edge 65.
